// File: rtl/pri_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pri_sync_fifo
// Description : Small synchronous FIFO. Full and empty come from an occupancy
//               counter, so the pointers can wrap freely at DEPTH. A push into
//               a full queue is accepted when a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module pri_sync_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_wr_v,
    input  logic [WIDTH-1:0]           i_wr_data,
    input  logic                       i_rd_rdy,
    output logic                       o_wr_acc,
    output logic [WIDTH-1:0]           o_rd_data,
    output logic                       o_rd_v,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] c_depth = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             w_empty;
    logic             w_pop;
    logic             w_push;

    assign w_empty = (r_count == '0);
    // out_rdy has no effect while the queue is empty
    assign w_pop   = ~w_empty & i_rd_rdy;
    // a pop frees the slot the push needs, even when full
    assign w_push  = i_wr_v & ((r_count < c_depth) | w_pop);

    // Storage write; contents are don't-care after reset, so no reset here
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers advance on accepted push/pop and wrap naturally at DEPTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy: simultaneous push and pop leaves it unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_wr_acc  = w_push;
    // Head is forced to zero while empty so stale storage never shows
    assign o_rd_data = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_rd_v    = ~w_empty;
    assign o_count   = r_count;
    assign o_full    = (r_count == c_depth);
    assign o_empty   = w_empty;

endmodule
`default_nettype wire

// File: rtl/pri_grant_queue.sv
`default_nettype none
// ============================================================================
// Module      : pri_grant_queue
// Description : Queues encoded indices from the priority encoder and presents
//               them to a consumer as a binary index plus a one-hot grant.
//               Pushes lost to a full queue set a sticky flag and bump a
//               saturating drop counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pri_grant_queue #(
    parameter int DWIDTH = 16,
    parameter int DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [$clog2(DWIDTH)-1:0]   in_idx,
    input  logic                        in_v,
    output logic [$clog2(DWIDTH)-1:0]   out_idx,
    output logic [DWIDTH-1:0]           out_onehot,
    output logic                        out_v,
    input  logic                        out_rdy,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        full,
    output logic                        empty,
    output logic                        ovf,
    output logic [7:0]                  drop_cnt,
    input  logic                        clr_ovf
);

    localparam int IW = $clog2(DWIDTH);
    localparam int PW = $clog2(DEPTH);
    localparam logic [7:0] c_drop_max = 8'hFF;

    logic          w_push;
    logic          w_drop;
    logic          r_ovf;
    logic [7:0]    r_drop_cnt;
    logic [IW-1:0] w_head;
    logic          w_head_v;
    logic [PW:0]   w_count;
    logic          w_full;
    logic          w_empty;

    pri_sync_fifo #(
        .WIDTH (IW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_wr_v    (in_v),
        .i_wr_data (in_idx),
        .i_rd_rdy  (out_rdy),
        .o_wr_acc  (w_push),
        .o_rd_data (w_head),
        .o_rd_v    (w_head_v),
        .o_count   (w_count),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign w_drop = in_v & ~w_push;

    // Sticky overflow and saturating drop count; a drop beats a clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
            if (clr_ovf) begin
                r_drop_cnt <= 8'd1;
            end else if (r_drop_cnt != c_drop_max) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end else if (clr_ovf) begin
            r_ovf      <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

    // One-hot grant: each bit matches its own index, gated by valid
    for (genvar i = 0; i < DWIDTH; i++) begin : g_onehot
        assign out_onehot[i] = w_head_v & (w_head == IW'(i));
    end

    assign out_idx  = w_head;
    assign out_v    = w_head_v;
    assign count    = w_count;
    assign full     = w_full;
    assign empty    = w_empty;
    assign ovf      = r_ovf;
    assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pri_grant_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_pri_grant_queue
// Description : Directed table-driven bench for pri_grant_queue (DWIDTH=16,
//               DEPTH=4) plus hand-written saturation and async reset cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pri_grant_queue;

    logic        clk;
    logic        rst;
    logic [3:0]  in_idx;
    logic        in_v;
    logic [3:0]  out_idx;
    logic [15:0] out_onehot;
    logic        out_v;
    logic        out_rdy;
    logic [2:0]  count;
    logic        full;
    logic        empty;
    logic        ovf;
    logic [7:0]  drop_cnt;
    logic        clr_ovf;

    int n_checks = 0;
    int n_errors = 0;

    pri_grant_queue #(
        .DWIDTH (16),
        .DEPTH  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_idx     (in_idx),
        .in_v       (in_v),
        .out_idx    (out_idx),
        .out_onehot (out_onehot),
        .out_v      (out_v),
        .out_rdy    (out_rdy),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .ovf        (ovf),
        .drop_cnt   (drop_cnt),
        .clr_ovf    (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  idx;
        logic        v;
        logic        rdy;
        logic        clr;
        logic [3:0]  e_idx;
        logic [15:0] e_oh;
        logic [2:0]  e_cnt;
        logic        e_ovf;
        logic [7:0]  e_drop;
    } vec_t;

    vec_t vecs [34];

    function automatic vec_t mk(input logic [3:0] idx, input logic v, input logic rdy,
                                input logic clr, input logic [3:0] e_idx,
                                input logic [15:0] e_oh, input logic [2:0] e_cnt,
                                input logic e_ovf, input logic [7:0] e_drop);
        vec_t r;
        r.idx = idx; r.v = v; r.rdy = rdy; r.clr = clr;
        r.e_idx = e_idx; r.e_oh = e_oh; r.e_cnt = e_cnt;
        r.e_ovf = e_ovf; r.e_drop = e_drop;
        return r;
    endfunction

    task automatic chk(input string name, input int tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s (step %0d): got %h, expected %h", name, tag, act, exp);
        end
    endtask

    // Full output check; out_v, full and empty follow from the expected count
    task automatic chk_all(input int tag, input logic [3:0] e_idx, input logic [15:0] e_oh,
                           input logic [2:0] e_cnt, input logic e_ovf, input logic [7:0] e_drop);
        chk("out_v",      tag, 32'(out_v),      32'(e_cnt != 3'd0));
        chk("out_idx",    tag, 32'(out_idx),    32'(e_idx));
        chk("out_onehot", tag, 32'(out_onehot), 32'(e_oh));
        chk("count",      tag, 32'(count),      32'(e_cnt));
        chk("full",       tag, 32'(full),       32'(e_cnt == 3'd4));
        chk("empty",      tag, 32'(empty),      32'(e_cnt == 3'd0));
        chk("ovf",        tag, 32'(ovf),        32'(e_ovf));
        chk("drop_cnt",   tag, 32'(drop_cnt),   32'(e_drop));
    endtask

    // Drive one cycle of inputs; outputs are sampled 1 time unit after the edge
    task automatic step(input logic [3:0] idx, input logic v, input logic rdy, input logic clr);
        in_idx  = idx;
        in_v    = v;
        out_rdy = rdy;
        clr_ovf = clr;
        @(posedge clk);
        #1;
        in_v    = 1'b0;
        out_rdy = 1'b0;
        clr_ovf = 1'b0;
    endtask

    initial begin
        //                 idx v  rdy clr  e_idx e_oh      cnt ovf drop
        vecs[0]  = mk(4'd0,  0, 0, 0, 4'd0,  16'h0000, 0, 0, 0);
        vecs[1]  = mk(4'd5,  1, 0, 0, 4'd5,  16'h0020, 1, 0, 0);
        vecs[2]  = mk(4'd0,  0, 1, 0, 4'd0,  16'h0000, 0, 0, 0);
        vecs[3]  = mk(4'd3,  1, 0, 0, 4'd3,  16'h0008, 1, 0, 0);
        vecs[4]  = mk(4'd7,  1, 0, 0, 4'd3,  16'h0008, 2, 0, 0);
        vecs[5]  = mk(4'd1,  1, 0, 0, 4'd3,  16'h0008, 3, 0, 0);
        vecs[6]  = mk(4'd9,  1, 0, 0, 4'd3,  16'h0008, 4, 0, 0);
        vecs[7]  = mk(4'd0,  0, 1, 0, 4'd7,  16'h0080, 3, 0, 0);
        vecs[8]  = mk(4'd0,  0, 1, 0, 4'd1,  16'h0002, 2, 0, 0);
        vecs[9]  = mk(4'd0,  0, 1, 0, 4'd9,  16'h0200, 1, 0, 0);
        vecs[10] = mk(4'd0,  0, 1, 0, 4'd0,  16'h0000, 0, 0, 0);
        vecs[11] = mk(4'd2,  1, 0, 0, 4'd2,  16'h0004, 1, 0, 0);
        vecs[12] = mk(4'd4,  1, 0, 0, 4'd2,  16'h0004, 2, 0, 0);
        vecs[13] = mk(4'd6,  1, 0, 0, 4'd2,  16'h0004, 3, 0, 0);
        vecs[14] = mk(4'd8,  1, 0, 0, 4'd2,  16'h0004, 4, 0, 0);
        vecs[15] = mk(4'd12, 1, 1, 0, 4'd4,  16'h0010, 4, 0, 0);
        vecs[16] = mk(4'd0,  0, 1, 0, 4'd6,  16'h0040, 3, 0, 0);
        vecs[17] = mk(4'd0,  0, 1, 0, 4'd8,  16'h0100, 2, 0, 0);
        vecs[18] = mk(4'd0,  0, 1, 0, 4'd12, 16'h1000, 1, 0, 0);
        vecs[19] = mk(4'd0,  1, 1, 0, 4'd0,  16'h0001, 1, 0, 0);
        vecs[20] = mk(4'd0,  0, 1, 0, 4'd0,  16'h0000, 0, 0, 0);
        vecs[21] = mk(4'd15, 1, 1, 0, 4'd15, 16'h8000, 1, 0, 0);
        vecs[22] = mk(4'd15, 1, 0, 0, 4'd15, 16'h8000, 2, 0, 0);
        vecs[23] = mk(4'd15, 1, 0, 0, 4'd15, 16'h8000, 3, 0, 0);
        vecs[24] = mk(4'd15, 1, 0, 0, 4'd15, 16'h8000, 4, 0, 0);
        vecs[25] = mk(4'd1,  1, 0, 0, 4'd15, 16'h8000, 4, 1, 1);
        vecs[26] = mk(4'd1,  1, 0, 0, 4'd15, 16'h8000, 4, 1, 2);
        vecs[27] = mk(4'd1,  1, 0, 0, 4'd15, 16'h8000, 4, 1, 3);
        vecs[28] = mk(4'd1,  1, 0, 1, 4'd15, 16'h8000, 4, 1, 1);
        vecs[29] = mk(4'd0,  0, 0, 1, 4'd15, 16'h8000, 4, 0, 0);
        vecs[30] = mk(4'd0,  0, 1, 0, 4'd15, 16'h8000, 3, 0, 0);
        vecs[31] = mk(4'd0,  0, 1, 0, 4'd15, 16'h8000, 2, 0, 0);
        vecs[32] = mk(4'd0,  0, 1, 0, 4'd15, 16'h8000, 1, 0, 0);
        vecs[33] = mk(4'd0,  0, 1, 0, 4'd0,  16'h0000, 0, 0, 0);

        in_idx = '0; in_v = 1'b0; out_rdy = 1'b0; clr_ovf = 1'b0;
        rst = 1'b1;
        #1;
        chk_all(-1, 4'd0, 16'h0000, 3'd0, 1'b0, 8'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset then idle
        for (int i = 0; i < 5; i++) begin
            step(4'd0, 1'b0, 1'b0, 1'b0);
            chk_all(100 + i, 4'd0, 16'h0000, 3'd0, 1'b0, 8'd0);
        end

        // Directed table
        for (int i = 0; i < 34; i++) begin
            step(vecs[i].idx, vecs[i].v, vecs[i].rdy, vecs[i].clr);
            chk_all(i, vecs[i].e_idx, vecs[i].e_oh, vecs[i].e_cnt, vecs[i].e_ovf, vecs[i].e_drop);
        end

        // Saturation: fill, then 300 drops
        step(4'd10, 1'b1, 1'b0, 1'b0);
        step(4'd11, 1'b1, 1'b0, 1'b0);
        step(4'd12, 1'b1, 1'b0, 1'b0);
        step(4'd13, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            step(4'd3, 1'b1, 1'b0, 1'b0);
        end
        chk_all(200, 4'd10, 16'h0400, 3'd4, 1'b1, 8'd255);

        // Two pops leave 2 entries queued; counter stays saturated
        step(4'd0, 1'b0, 1'b1, 1'b0);
        step(4'd0, 1'b0, 1'b1, 1'b0);
        chk_all(201, 4'd12, 16'h1000, 3'd2, 1'b1, 8'd255);

        // Async reset mid-cycle: outputs clear before the next rising edge
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_all(202, 4'd0, 16'h0000, 3'd0, 1'b0, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        // First push after reset behaves as on an empty queue
        step(4'd7, 1'b1, 1'b0, 1'b0);
        chk_all(203, 4'd7, 16'h0080, 3'd1, 1'b0, 8'd0);
        step(4'd0, 1'b0, 1'b1, 1'b0);
        chk_all(204, 4'd0, 16'h0000, 3'd0, 1'b0, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pri_grant_queue.md
Name: pri_grant_queue

Overview:
- Downstream stage of the priority encoder.
- Captures each valid encoded index (index + valid, one per cycle) into a small FIFO.
- Presents queued indices to the consumer over a valid/ready handshake, both as a binary index and as a one-hot grant vector.
- Counts and flags any index dropped because the queue was full.

Parameters:
DWIDTH, 16, request vector width; index width is IW = $clog2(DWIDTH)
DEPTH, 4, queue entries; must be a power of two and at least 2; pointer width PW = $clog2(DEPTH)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
in_idx  in  IW  encoded index from the priority encoder
in_v  in  1  in_idx valid; push request
out_idx  out  IW  head-of-queue index
out_onehot  out  DWIDTH  one-hot decode of out_idx; all zeros when out_v=0
out_v  out  1  queue not empty
out_rdy  in  1  consumer accepts head when out_v=1
count  out  PW+1  occupancy, 0..DEPTH
full  out  1  count==DEPTH
empty  out  1  count==0
ovf  out  1  sticky overflow flag
drop_cnt  out  8  saturating count of dropped pushes
clr_ovf  in  1  synchronous clear of ovf and drop_cnt

Behaviour:
- Reset (async, rst=1):
  - Pointers = 0; count = 0; ovf = 0; drop_cnt = 0.
  - out_v = 0; out_idx = 0; out_onehot = 0; empty = 1; full = 0.
  - Storage contents are don't-care.
- Pop: pop = out_v & out_rdy. Advances the read pointer at the clock edge. out_rdy is ignored when out_v=0.
- Push acceptance: push = in_v & (count<DEPTH | pop).
  - A push into a full queue is accepted if a pop happens in the same cycle.
  - Writes in_idx at the write pointer and advances it.
- Count update:
  - push & pop: count unchanged.
  - push only: +1.
  - pop only: -1.
- Latency:
  - Push into an empty queue at edge N gives out_v=1 and out_idx valid after edge N.
  - No combinational path from in_* to out_*.
- Head decode:
  - out_idx is driven directly from the head storage entry; out_v = ~empty.
  - out_onehot[out_idx] = 1 when out_v=1; out_onehot = 0 otherwise.
- Pointer wrap: pointers are PW bits and wrap naturally at DEPTH. Full/empty are derived from count, not from pointer comparison.
- Drop (in_v & ~push):
  - in_idx is discarded.
  - ovf <= 1.
  - drop_cnt <= min(drop_cnt+1, 255); holds at 255.
- clr_ovf:
  - On a cycle with no drop: ovf <= 0 and drop_cnt <= 0.
  - On the same cycle as a drop, the drop wins: ovf stays 1 and drop_cnt <= 1.
- Ordering: strict FIFO. Duplicate indices are queued as separate entries (no merging).
- Empty queue: a simultaneous in_v and out_rdy is a push only. The entry is visible the next cycle (no fall-through bypass).
- Reset mid-operation: all queued entries are lost. Outputs return to reset values immediately (asynchronous). The first push after rst deasserts behaves as on an empty queue.

Decomposition:
- No shared package required.
- IW and PW are localparams computed from the parameters.
- One natural sub-module: pri_sync_fifo (parameters WIDTH, DEPTH).
  - Owns storage, pointers, count, full and empty.
  - Uses the same push/pop rule as above.
- pri_grant_queue owns the one-hot decode, overflow logic and drop counter.

Test Plan:
- Reset then idle: rst pulse, in_v=0 for 5 cycles -> out_v=0, out_onehot=0, empty=1, count=0, ovf=0, drop_cnt=0.
- Single pass, DWIDTH=16: in_idx=5 with in_v=1 for 1 cycle, out_rdy=0 -> next cycle out_v=1, out_idx=5, out_onehot=16'h0020, count=1. Then out_rdy=1 for 1 cycle -> empty=1 the following cycle.
- Order and wrap, DEPTH=4: push 3,7,1,9 then pop all; repeat with 2,4,6,8 -> pops are 3,7,1,9,2,4,6,8 in order, full=1 after the 4th push each time.
- Full with simultaneous pop: queue holds 4 entries, in_idx=12 with in_v=1 and out_rdy=1 -> count stays 4, no drop, 12 emerges last.
- Overflow: queue full, out_rdy=0, 3 cycles of in_v=1 -> ovf=1, drop_cnt=3, queue contents unchanged. Then clr_ovf=1 coincident with a 4th drop -> ovf=1, drop_cnt=1. Then clr_ovf=1 alone -> ovf=0, drop_cnt=0.
- Saturation and async reset: 300 drops -> drop_cnt=255. Assert rst mid-cycle with 2 entries queued -> out_v, count and drop_cnt drop to 0 before the next clk edge.
